// File: rtl/spi_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_frame_ctrl_if
//  Description : Bundle of SPI-word, filter handshake and statistics signals
//                between the SPI frame controller and its surroundings.
//                slave  = controller side, master = environment side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_frame_ctrl_if #(
    parameter int DW = 14
);
    logic          word_valid;
    logic [DW-1:0] word_data;
    logic          filt_start;
    logic [DW-1:0] filt_d;
    logic [DW-1:0] filt_x;
    logic          filt_done;
    logic [DW-1:0] filt_y;
    logic          tx_load;
    logic [DW-1:0] tx_data;
    logic          busy;
    logic          frame_err;
    logic [15:0]   frame_cnt;
    logic [7:0]    err_cnt;

    modport slave (
        input  word_valid, word_data, filt_done, filt_y,
        output filt_start, filt_d, filt_x, tx_load, tx_data,
               busy, frame_err, frame_cnt, err_cnt
    );

    modport master (
        output word_valid, word_data, filt_done, filt_y,
        input  filt_start, filt_d, filt_x, tx_load, tx_data,
               busy, frame_err, frame_cnt, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/spi_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_frame_ctrl
//  Description : Parses SPI word frames (header, desired sample, input sample),
//                kicks one adaptive-filter iteration per frame, waits for the
//                result with a timeout and hands it to the MISO shift register.
//                Optional statistics counters are built only when the macro
//                FRAME_STATS_EN is defined; otherwise they read constant zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_ctrl #(
    parameter int            DW      = 14,
    parameter logic [DW-1:0] HDR     = 14'h0FFF,
    parameter int            TIMEOUT = 256
) (
    input  wire logic        clk,
    input  wire logic        rst,
    spi_frame_ctrl_if.slave  bus
);

    // Timeout counter is wide enough to hold TIMEOUT-1.
    localparam int            c_cnt_w    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GET_D = 3'd1,
        S_GET_X = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_LOAD  = 3'd5
    } state_t;

    state_t              r_state_q,   w_state_d;
    logic [DW-1:0]       r_filt_d_q,  w_filt_d_d;
    logic [DW-1:0]       r_filt_x_q,  w_filt_x_d;
    logic [DW-1:0]       r_tx_data_q, w_tx_data_d;
    logic [c_cnt_w-1:0]  r_tmo_q,     w_tmo_d;
    logic                w_word_err;
    logic                w_tmo_err;
    logic                w_is_hdr;
    logic                w_frame_err;

    assign w_is_hdr = (bus.word_data == HDR);

    // Next-state, sample capture, timeout counting and error detection.
    always_comb begin
        w_state_d   = r_state_q;
        w_filt_d_d  = r_filt_d_q;
        w_filt_x_d  = r_filt_x_q;
        w_tx_data_d = r_tx_data_q;
        w_tmo_d     = r_tmo_q;
        w_word_err  = 1'b0;
        w_tmo_err   = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (bus.word_valid) begin
                    if (w_is_hdr) begin
                        w_state_d = S_GET_D;
                    end else begin
                        w_word_err = 1'b1;
                    end
                end
            end
            S_GET_D: begin
                if (bus.word_valid) begin
                    if (w_is_hdr) begin
                        // Header mid-frame: resynchronise on it.
                        w_word_err = 1'b1;
                        w_state_d  = S_GET_D;
                    end else begin
                        w_filt_d_d = bus.word_data;
                        w_state_d  = S_GET_X;
                    end
                end
            end
            S_GET_X: begin
                if (bus.word_valid) begin
                    if (w_is_hdr) begin
                        w_word_err = 1'b1;
                        w_state_d  = S_GET_D;
                    end else begin
                        w_filt_x_d = bus.word_data;
                        w_state_d  = S_START;
                    end
                end
            end
            S_START: begin
                w_word_err = bus.word_valid;
                w_tmo_d    = '0;
                w_state_d  = S_WAIT;
            end
            S_WAIT: begin
                w_word_err = bus.word_valid;
                // A result arriving on the last allowed cycle still counts.
                if (bus.filt_done) begin
                    w_tx_data_d = bus.filt_y;
                    w_state_d   = S_LOAD;
                end else if (r_tmo_q == c_tmo_last) begin
                    w_tmo_err = 1'b1;
                    w_state_d = S_IDLE;
                end else begin
                    w_tmo_d = r_tmo_q + c_cnt_w'(1);
                end
            end
            S_LOAD: begin
                w_word_err = bus.word_valid;
                w_state_d  = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Simultaneous error sources collapse into one pulse.
        w_frame_err = (w_word_err | w_tmo_err) & ~rst;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= S_IDLE;
            r_filt_d_q  <= '0;
            r_filt_x_q  <= '0;
            r_tx_data_q <= '0;
            r_tmo_q     <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_filt_d_q  <= w_filt_d_d;
            r_filt_x_q  <= w_filt_x_d;
            r_tx_data_q <= w_tx_data_d;
            r_tmo_q     <= w_tmo_d;
        end
    end

    assign bus.filt_start = (r_state_q == S_START);
    assign bus.tx_load    = (r_state_q == S_LOAD);
    assign bus.busy       = (r_state_q == S_START) ||
                            (r_state_q == S_WAIT)  ||
                            (r_state_q == S_LOAD);
    assign bus.filt_d     = r_filt_d_q;
    assign bus.filt_x     = r_filt_x_q;
    assign bus.tx_data    = r_tx_data_q;
    assign bus.frame_err  = w_frame_err;

`ifdef FRAME_STATS_EN
    logic [15:0] r_frame_cnt_q, w_frame_cnt_d;
    logic [7:0]  r_err_cnt_q,   w_err_cnt_d;

    // Saturating frame and error statistics.
    always_comb begin
        w_frame_cnt_d = r_frame_cnt_q;
        w_err_cnt_d   = r_err_cnt_q;
        if ((r_state_q == S_LOAD) && (r_frame_cnt_q != 16'hFFFF)) begin
            w_frame_cnt_d = r_frame_cnt_q + 16'd1;
        end
        if (w_frame_err && (r_err_cnt_q != 8'hFF)) begin
            w_err_cnt_d = r_err_cnt_q + 8'd1;
        end
    end

    // Statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt_q <= '0;
            r_err_cnt_q   <= '0;
        end else begin
            r_frame_cnt_q <= w_frame_cnt_d;
            r_err_cnt_q   <= w_err_cnt_d;
        end
    end

    assign bus.frame_cnt = r_frame_cnt_q;
    assign bus.err_cnt   = r_err_cnt_q;
`else
    assign bus.frame_cnt = 16'd0;
    assign bus.err_cnt   = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_frame_ctrl
//  Description : Self-checking bench for spi_frame_ctrl. Frames are described
//                as transactions (samples, result delay, result value, stray
//                word position); expected pulses, captured samples, tx_data and
//                statistics are derived from the frame protocol rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_frame_ctrl;

    localparam int            DW      = 14;
    localparam logic [DW-1:0] HDR     = 14'h0FFF;
    localparam int            TIMEOUT = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    // Expected state kept at transaction level.
    logic [DW-1:0] exp_tx     = '0;
    int            exp_frames = 0;
    int            exp_errs   = 0;

    // Outputs sampled mid-cycle by cyc().
    logic s_err, s_start, s_load, s_busy;

    spi_frame_ctrl_if #(.DW(DW)) vif ();

    spi_frame_ctrl #(
        .DW      (DW),
        .HDR     (HDR),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running required=finished");
        $fatal(1, "simulation time limit exceeded");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        w = DW'($urandom);
        if (w == HDR) w[0] = ~w[0];
        return w;
    endfunction

    // One clock cycle: drive inputs, sample outputs on the falling edge,
    // return 1 time unit after the next rising edge.
    task automatic cyc(input logic wv, input logic [DW-1:0] wd,
                       input logic fd, input logic [DW-1:0] fy);
        vif.word_valid = wv;
        vif.word_data  = wd;
        vif.filt_done  = fd;
        vif.filt_y     = fy;
        @(negedge clk);
        s_err   = vif.frame_err;
        s_start = vif.filt_start;
        s_load  = vif.tx_load;
        s_busy  = vif.busy;
        @(posedge clk);
        #1;
        vif.word_valid = 1'b0;
        vif.filt_done  = 1'b0;
    endtask

    task automatic chk_stats();
`ifdef FRAME_STATS_EN
        chk("frame_cnt", {16'd0, vif.frame_cnt}, (exp_frames > 65535) ? 65535 : exp_frames);
        chk("err_cnt",   {24'd0, vif.err_cnt},   (exp_errs > 255) ? 255 : exp_errs);
`else
        chk("frame_cnt", {16'd0, vif.frame_cnt}, 0);
        chk("err_cnt",   {24'd0, vif.err_cnt},   0);
`endif
    endtask

    // One frame. delay: WAIT cycle (1..TIMEOUT) carrying filt_done, 0 = never.
    // inj: WAIT cycle carrying a stray word, 0 = none. skip_hdr: header already sent.
    task automatic do_frame(input logic [DW-1:0] d, input logic [DW-1:0] x,
                            input int delay, input logic [DW-1:0] y,
                            input int inj, input bit skip_hdr);
        logic dn, wv, e;
        if (!skip_hdr) begin
            cyc(1'b1, HDR, 1'b0, '0);
            chk("hdr_err", s_err, 0);
        end
        cyc(1'b1, d, 1'b0, '0);
        chk("d_err", s_err, 0);
        cyc(1'b1, x, 1'b0, '0);
        chk("x_err", s_err, 0);
        chk("start_early", s_start, 0);
        chk("filt_d", vif.filt_d, d);
        chk("filt_x", vif.filt_x, x);
        cyc(1'b0, '0, 1'b0, '0);
        chk("start", s_start, 1);
        chk("busy_start", s_busy, 1);
        for (int k = 1; k <= TIMEOUT; k++) begin
            dn = (delay == k);
            wv = (inj == k);
            cyc(wv, rand_word(), dn, y);
            e = wv || (delay == 0 && k == TIMEOUT);
            if (e) exp_errs++;
            chk("wait_err", s_err, e);
            chk("wait_start", s_start, 0);
            chk("wait_load", s_load, 0);
            if (dn) break;
        end
        if (delay != 0) begin
            exp_tx = y;
            exp_frames++;
            cyc(1'b0, '0, 1'b0, '0);
            chk("tx_load", s_load, 1);
            chk("tx_data", vif.tx_data, exp_tx);
        end
        cyc(1'b0, '0, 1'b0, '0);
        chk("post_load", s_load, 0);
        chk("post_busy", s_busy, 0);
        chk("tx_hold", vif.tx_data, exp_tx);
        chk_stats();
    endtask

    initial begin
        vif.word_valid = 1'b0;
        vif.word_data  = '0;
        vif.filt_done  = 1'b0;
        vif.filt_y     = '0;
        rst = 1'b1;
        repeat (2) cyc(1'b0, '0, 1'b0, '0);
        rst = 1'b0;

        // Reset state.
        chk("rst_filt_d", vif.filt_d, 0);
        chk("rst_filt_x", vif.filt_x, 0);
        chk("rst_tx_data", vif.tx_data, 0);
        chk("rst_busy", vif.busy, 0);
        chk("rst_start", vif.filt_start, 0);
        chk("rst_load", vif.tx_load, 0);
        chk_stats();

        // Basic frame with fixed values.
        do_frame(14'h054B, 14'h054C, 3, 14'h0123, 0, 1'b0);

        // Garbage before a header.
        cyc(1'b1, 14'h0001, 1'b0, '0);
        exp_errs++;
        chk("garbage_err", s_err, 1);
        cyc(1'b0, '0, 1'b0, '0);
        chk("garbage_one_pulse", s_err, 0);
        do_frame(14'h0100, 14'h0101, 2, 14'h0222, 0, 1'b0);

        // Header resync inside a frame.
        cyc(1'b1, HDR, 1'b0, '0);
        cyc(1'b1, 14'h0200, 1'b0, '0);
        chk("resync_d_err", s_err, 0);
        cyc(1'b1, HDR, 1'b0, '0);
        exp_errs++;
        chk("resync_err", s_err, 1);
        chk("resync_start", s_start, 0);
        do_frame(14'h0300, 14'h0301, 4, 14'h0333, 0, 1'b1);

        // Result withheld: timeout, tx_data keeps the previous result.
        do_frame(rand_word(), rand_word(), 0, '0, 0, 1'b0);

        // Stray word during WAIT, then the result.
        do_frame(rand_word(), rand_word(), 5, 14'h0444, 2, 1'b0);

        // Result on the last allowed cycle wins over the timeout.
        do_frame(rand_word(), rand_word(), TIMEOUT, 14'h0555, 0, 1'b0);

        // filt_done outside WAIT is ignored.
        cyc(1'b0, '0, 1'b1, 14'h1111);
        chk("stray_done_err", s_err, 0);
        cyc(1'b0, '0, 1'b0, '0);
        chk("stray_done_load", s_load, 0);
        chk("stray_done_tx", vif.tx_data, exp_tx);

        // Randomized traffic.
        for (int i = 0; i < 25; i++) begin
            int kind;
            int dl;
            int ij;
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                cyc(1'b1, rand_word(), 1'b0, '0);
                exp_errs++;
                chk("rnd_garbage_err", s_err, 1);
                chk("rnd_garbage_busy", s_busy, 0);
            end else begin
                dl = $urandom_range(1, 12);
                ij = (kind == 3) ? $urandom_range(1, dl) : 0;
                do_frame(rand_word(), rand_word(), dl, rand_word(), ij, 1'b0);
            end
            cyc(1'b0, '0, 1'($urandom_range(0, 1)), rand_word());
            chk("rnd_gap_err", s_err, 0);
            chk("rnd_gap_load", s_load, 0);
            chk_stats();
        end

        // Reset while in GET_X discards the frame.
        cyc(1'b1, HDR, 1'b0, '0);
        cyc(1'b1, 14'h0123, 1'b0, '0);
        rst = 1'b1;
        cyc(1'b0, '0, 1'b0, '0);
        rst = 1'b0;
        exp_tx = '0;
        exp_frames = 0;
        exp_errs = 0;
        chk("mid_rst_filt_d", vif.filt_d, 0);
        chk("mid_rst_filt_x", vif.filt_x, 0);
        chk("mid_rst_tx", vif.tx_data, 0);
        chk("mid_rst_busy", vif.busy, 0);
        chk_stats();
        cyc(1'b1, 14'h0400, 1'b0, '0);
        exp_errs++;
        chk("post_rst_err", s_err, 1);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, '0, 1'b0, '0);
            chk("post_rst_start", s_start, 0);
            chk("post_rst_load", s_load, 0);
        end
        chk_stats();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
